mem_word_sequencer: RTL
=======================

// Module: mem_word_sequencer
// PURPOSE
//   Multi-cycle byte-serial load/store engine between a WORD_BYTES-wide data
//   word and the 8-bit Memory. It replaces hand-sequenced DR/MuxC byte
//   control with one request/done handshake. A store writes 1..WORD_BYTES
//   bytes, and a load reads and assembles them with zero- or sign-extension.
//   Byte order is selected by a parameter. It sits between the
//   control unit/ARF (address) and Memory, and feeds the register-file input mux.
// PARAMETERS
//   WORD_BYTES  4  bytes per word; power of two, >=2; data width DW = 8*WORD_BYTES
//   ADDR_W      16 memory address width
//   BIG_ENDIAN  0  0: byte k of value at Base+k; 1: most-significant used byte at Base
// PORTS
//   Clock        in  1       rising-edge clock
//   Reset        in  1       asynchronous, active-low reset
//   Start        in  1       request; accepted on an edge where Start=1 and Ready=1
//   Write        in  1       1=store, 0=load; sampled at accept
//   Len          in  LW      byte count minus 1, LW=$clog2(WORD_BYTES); sampled at accept
//   SignExt      in  1       load only: 1=sign-extend from bit 8*(Len+1)-1; sampled at accept
//   BaseAddr     in  ADDR_W  first byte address; sampled at accept
//   WData        in  DW      store data, low Len+1 bytes used; sampled at accept
//   Ready        out 1       1 when IDLE (may accept)
//   Done         out 1       one-cycle pulse: operation complete
//   RData        out DW      assembled load result; holds until the next load completes
//   Mem_Address  out ADDR_W  byte address to Memory
//   Mem_Data     out 8       byte to Memory (store)
//   Mem_WR       out 1       1=write, 0=read
//   Mem_CS       out 1       active-low chip select
//   MemOut       in  8       Memory read data; valid in the cycle after address/CS are presented
// BEHAVIOUR
//   Reset (async, Reset=0): state=IDLE, Ready=1, Done=0, RData=0, Mem_CS=1,
//     Mem_WR=0, Mem_Address=0, Mem_Data=0. This takes effect immediately, also mid-operation.
//     The partial transfer is discarded and no further memory cycle is issued.
//   States: IDLE -> STORE | LOAD -> (LOAD only) LAST -> IDLE.
//   Cycle c = the c-th cycle after the accept edge; N = Len+1.
//   All Mem_* outputs are decoded from registered state only; no input-to-output paths.
//   STORE: in cycles 0..N-1, drive Mem_CS=0, Mem_WR=1, Mem_Address=Base+k, and
//     Mem_Data=byte k in order. Then IDLE with Done=1 and Ready=1 in cycle N.
//   LOAD: in cycles 0..N-1, drive Mem_CS=0, Mem_WR=0, Mem_Address=Base+k. Capture
//     MemOut into the shift/assembly register at the end of cycles 1..N
//     (state LAST in cycle N: Mem_CS=1). RData updates on the same edge that
//     enters IDLE. Done=1 and Ready=1 in cycle N+1.
//   Idle/LAST: Mem_CS=1, Mem_WR=0, Mem_Address=0, Mem_Data=0.
//   Order: BIG_ENDIAN=0 -> byte at Base+k is bits [8k+7:8k]. BIG_ENDIAN=1 ->
//     byte at Base+k is bits [8(N-1-k)+7:8(N-1-k)].
//   Load result: low 8N bits assembled. Upper bits = 0, or replicated bit 8N-1 if
//     SignExt=1. Len=WORD_BYTES-1 ignores SignExt.
//   Address arithmetic is modulo 2^ADDR_W; Base+k wraps from all-ones to 0.
//   Start while busy is ignored (no queueing). Input changes after accept have no effect.
//   Back-to-back: Start=1 in the Done cycle is accepted; the next op's cycle 0
//     directly follows, with no idle bubble.
//   Done is asserted for exactly 1 cycle per completed op; never after reset abort.
//   RData is unchanged by stores.
// TESTING (WORD_BYTES=4, ADDR_W=16 unless noted)
//   1. Store, Len=3, Base=0x0010, WData=0xA1B2C3D4, BIG_ENDIAN=0 -> writes
//      D4@0010, C3@0011, B2@0012, A1@0013 in cycles 0-3; Done in cycle 4.
//   2. Load, Len=1, mem[0020]=0x34, mem[0021]=0x92: with SignExt=1 -> RData=0xFFFF9234;
//      with SignExt=0 -> 0x00009234. Done in cycle 3 in both cases.
//   3. BIG_ENDIAN=1, load, Len=3, mem[0040..0043]=11,22,33,44 -> RData=0x11223344.
//      Store 0x11223344 -> 11@0040 .. 44@0043.
//   4. Store, Len=1, Base=0xFFFF -> addresses FFFF then 0000; no other address driven.
//   5. Reset=0 in cycle 1 of a Len=3 store -> Mem_CS=1 and Ready=1 immediately,
//      RData=0, and no Done. After release, a new store runs normally.
//   6. Start held high while busy -> ignored; Start in the Done cycle -> second op
//      cycle 0 on the next cycle. Done pulses once per op.

Source files
------------

// File: rtl/mem_word_sequencer.sv
// Byte-serial load/store engine: moves 1..WORD_BYTES bytes between a data word
// and an 8-bit memory behind one Start/Done handshake.
module mem_word_sequencer #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 16,
  parameter bit BIG_ENDIAN = 1'b0,
  localparam int DW = 8 * WORD_BYTES,
  localparam int LW = $clog2(WORD_BYTES)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Write,
  input  logic [LW-1:0]     Len,
  input  logic              SignExt,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [DW-1:0]     WData,
  output logic              Ready,
  output logic              Done,
  output logic [DW-1:0]     RData,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [7:0]        Mem_Data,
  output logic              Mem_WR,
  output logic              Mem_CS,
  input  logic [7:0]        MemOut
);

  typedef enum logic [1:0] {IDLE, STORE, LOAD, LAST} state_t;

  state_t state_reg, state_next;

  // One extra bit so the count can sit at Len+1 while in LAST.
  logic [LW:0]       cnt_reg;
  logic [LW-1:0]     len_reg;
  logic              sext_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [DW-1:0]     wdata_reg;
  logic [DW-1:0]     asm_reg;
  logic [DW-1:0]     rdata_reg;
  logic              done_reg;

  logic              accept;
  logic              last_byte;
  logic              capture;
  logic [LW-1:0]     cap_k;
  logic [LW-1:0]     cap_pos;
  logic [LW-1:0]     store_idx;
  logic [DW-1:0]     asm_next;
  logic [DW-1:0]     ext_result;
  logic              sign_bit;

  assign accept    = Start && (state_reg == IDLE);
  assign last_byte = (cnt_reg == {1'b0, len_reg});

  // MemOut arriving now belongs to the address presented one cycle earlier.
  assign capture   = ((state_reg == LOAD) && (cnt_reg != '0)) || (state_reg == LAST);
  assign cap_k     = LW'(cnt_reg - 1'b1);
  assign cap_pos   = BIG_ENDIAN ? (len_reg - cap_k) : cap_k;
  assign store_idx = BIG_ENDIAN ? (len_reg - cnt_reg[LW-1:0]) : cnt_reg[LW-1:0];

  always_comb begin
    asm_next = asm_reg;
    asm_next[8*cap_pos +: 8] = MemOut;
  end

  assign sign_bit = asm_next[8*len_reg + 7];

  // Bytes above the transfer length are filled; stale assembly bytes never leak out.
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_ext
    assign ext_result[gi*8 +: 8] = (LW'(gi) > len_reg) ? {8{sext_reg & sign_bit}}
                                                        : asm_next[gi*8 +: 8];
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (Start) state_next = Write ? STORE : LOAD;
      STORE:   if (last_byte) state_next = IDLE;
      LOAD:    if (last_byte) state_next = LAST;
      LAST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_reg   <= '0;
      len_reg   <= '0;
      sext_reg  <= 1'b0;
      base_reg  <= '0;
      wdata_reg <= '0;
      asm_reg   <= '0;
      rdata_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      if (accept) begin
        cnt_reg   <= '0;
        len_reg   <= Len;
        sext_reg  <= SignExt;
        base_reg  <= BaseAddr;
        wdata_reg <= WData;
      end else if ((state_reg == STORE) || (state_reg == LOAD)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (capture) begin
        asm_reg <= asm_next;
      end
      if (state_reg == LAST) begin
        rdata_reg <= ext_result;
      end
      done_reg <= ((state_reg == STORE) && last_byte) || (state_reg == LAST);
    end
  end

  always_comb begin
    Mem_CS      = 1'b1;
    Mem_WR      = 1'b0;
    Mem_Address = '0;
    Mem_Data    = '0;
    case (state_reg)
      STORE: begin
        Mem_CS      = 1'b0;
        Mem_WR      = 1'b1;
        Mem_Address = base_reg + ADDR_W'(cnt_reg);
        Mem_Data    = wdata_reg[8*store_idx +: 8];
      end
      LOAD: begin
        Mem_CS      = 1'b0;
        Mem_Address = base_reg + ADDR_W'(cnt_reg);
      end
      default: ;
    endcase
  end

  assign Ready = (state_reg == IDLE);
  assign Done  = done_reg;
  assign RData = rdata_reg;

endmodule
